uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four requesters share one UART transmitter. A round-robin
// arbiter picks a requester, latches its byte and serialises it as
// start(0) / DATA_W data bits LSB first / stop(1). Back-to-back frames skip
// the ALIGN state so the line has no idle bit between consecutive frames.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   baud_tick  one-cycle strobe per bit period
//   req        per-requester transmit request (level)
//   req_data   requester i byte at [i*DATA_W +: DATA_W]
//   gnt        one-hot acceptance pulse, the cycle after capture
//   owner      index of the requester owning the current or last frame
//   busy       high whenever the transmitter is not idle
//   tx         serial output, idle high
module uart_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      baud_tick,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic                      tx
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   shift, shift_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                tx_nx;
  logic                busy_nx;
  logic [NUM_REQ-1:0]  gnt_nx;
  logic [1:0]          owner_nx;
  logic [1:0]          last_winner, last_nx;
  logic [1:0]          win;
  logic                grab;

  // Round-robin pick: first set request starting just after the last winner.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                         input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Next-state and next-output logic for the transmit FSM and arbiter.
  always_comb begin
    state_nx = state;
    shift_nx = shift;
    cnt_nx   = cnt;
    tx_nx    = tx;
    gnt_nx   = '0;
    owner_nx = owner;
    last_nx  = last_winner;
    grab     = 1'b0;
    win      = rr_pick(req, last_winner);

    case (state)
      IDLE: begin
        if (req != '0) begin
          grab     = 1'b1;
          state_nx = ALIGN;
        end else begin
          state_nx = IDLE;
        end
      end
      ALIGN: begin
        // Waits for a tick boundary so the start bit lasts a full period.
        if (baud_tick) begin
          tx_nx    = 1'b0;
          state_nx = START;
        end else begin
          tx_nx    = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_nx    = shift[0];
          shift_nx = {1'b0, shift[DATA_W-1:1]};
          cnt_nx   = '0;
          state_nx = DATA;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (baud_tick) begin
          // cnt is the index of the bit currently on the line.
          if (cnt == CNT_W'(DATA_W - 1)) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            tx_nx    = shift[0];
            shift_nx = {1'b0, shift[DATA_W-1:1]};
            cnt_nx   = cnt + CNT_W'(1);
          end
        end else begin
          state_nx = DATA;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (req != '0) begin
            // Back-to-back: new start bit begins right as stop bit ends.
            grab     = 1'b1;
            tx_nx    = 1'b0;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase

    if (grab) begin
      shift_nx = req_data[win*DATA_W +: DATA_W];
      owner_nx = win;
      last_nx  = win;
      gnt_nx   = NUM_REQ'(1) << win;
    end else begin
      last_nx  = last_winner;
    end

    busy_nx = (state_nx != IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      cnt         <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      gnt         <= '0;
      owner       <= 2'd0;
      last_winner <= 2'd3;
    end else begin
      state       <= state_nx;
      shift       <= shift_nx;
      cnt         <= cnt_nx;
      tx          <= tx_nx;
      busy        <= busy_nx;
      gnt         <= gnt_nx;
      owner       <= owner_nx;
      last_winner <= last_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A line decoder rebuilds frames from
// tx at each tick, and a round-robin reference model predicts each grant and
// the byte that must appear on the line.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        baud_tick = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [31:0] req_data = 32'b0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        tx;

  uart_tx_arbiter #(.DATA_W(8), .NUM_REQ(4)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .req(req),
    .req_data(req_data), .gnt(gnt), .owner(owner), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Stimulus-side state.
  int tick_per = 5;
  int tick_cnt = 0;
  bit hold = 1'b0;

  // Monitor / model state.
  int          model_last = 3;
  logic [7:0]  exp_q[$];
  int          gnt_log[$];
  int          start_q[$];
  logic        bit_log[$];
  bit          rx_active = 1'b0;
  int          nbit = 0;
  logic [7:0]  rx_byte = 8'h00;
  int          tick_idx = 0;
  int          frames_rx = 0;
  logic        tick_last = 1'b0;
  logic        tx_prev = 1'b1;
  logic [3:0]  req_prev = 4'b0;
  logic [31:0] data_prev = 32'b0;
  logic [3:0]  gnt_prev = 4'b0;

  function automatic int rr_model(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One clock of stimulus: granted requests are released, tick strobe advanced.
  task automatic step();
    @(posedge clk);
    #1;
    if (!hold) req = req & ~gnt;
    tick_cnt++;
    if (tick_cnt >= tick_per) begin
      tick_cnt  = 0;
      baud_tick = 1'b1;
    end else begin
      baud_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || rx_active || req != 4'b0) && n < budget) begin
      step();
      n++;
    end
    check_eq("wait_idle_bound", {31'b0, !(busy || rx_active || req != 4'b0)}, 32'd1);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (gnt_log.size() < target && n < budget) begin
      step();
      n++;
    end
    check_eq("wait_grants_bound", {31'b0, gnt_log.size() >= target}, 32'd1);
  endtask

  task automatic wait_rx_bit(input int k, input int budget);
    int n = 0;
    while (!(rx_active && nbit >= k) && n < budget) begin
      step();
      n++;
    end
    check_eq("wait_rx_bit_bound", {31'b0, rx_active && nbit >= k}, 32'd1);
  endtask

  // Monitor: samples on the falling edge, decodes the line, models grants.
  initial begin
    forever begin
      int w;
      @(negedge clk);
      if (reset) begin
        rx_active  = 1'b0;
        nbit       = 0;
        exp_q.delete();
        model_last = 3;
      end else begin
        if (tx !== tx_prev) check_eq("tx_moves_only_on_tick", {31'b0, tick_last}, 32'd1);
        if (tick_last) begin
          tick_idx++;
          if (!rx_active) begin
            if (tx == 1'b0) begin
              rx_active = 1'b1;
              nbit      = 0;
              rx_byte   = 8'h00;
              start_q.push_back(tick_idx);
              bit_log.push_back(tx);
            end
          end else if (nbit < 8) begin
            rx_byte[nbit] = tx;
            nbit++;
            bit_log.push_back(tx);
          end else begin
            bit_log.push_back(tx);
            check_eq("stop_bit", {31'b0, tx}, 32'd1);
            if (exp_q.size() == 0) check_eq("frame_without_grant", exp_q.size(), 32'd1);
            else check_eq("frame_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
            rx_active = 1'b0;
            frames_rx++;
          end
        end
        if (gnt !== 4'b0) begin
          w = rr_model(req_prev, model_last);
          check_eq("gnt_winner", {28'b0, gnt}, (w < 0) ? 32'd0 : (32'd1 << w));
          check_eq("gnt_single_cycle", {28'b0, gnt_prev}, 32'd0);
          if (w >= 0) begin
            check_eq("owner", {30'b0, owner}, w);
            model_last = w;
            exp_q.push_back(data_prev[w*8 +: 8]);
          end
          gnt_log.push_back(w);
        end
      end
      tick_last = baud_tick;
      tx_prev   = tx;
      req_prev  = req;
      data_prev = req_data;
      gnt_prev  = gnt;
    end
  end

  initial begin
    logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   order5 [5]    = '{0, 1, 2, 3, 0};
    int   g0;
    int   s0;
    int   f0;
    int   zeros;
    int   busy_cnt;
    int   r;

    // Reset values while reset is held.
    step();
    step();
    check_eq("rst_tx", {31'b0, tx}, 32'd1);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_gnt", {28'b0, gnt}, 32'd0);
    check_eq("rst_owner", {30'b0, owner}, 32'd0);
    reset = 1'b0;

    // Single frame, requester 2, byte 0xA5.
    bit_log.delete();
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    check_eq("single_gnt", {28'b0, gnt}, 32'h4);
    check_eq("single_owner", {30'b0, owner}, 32'd2);
    step();
    check_eq("single_gnt_end", {28'b0, gnt}, 32'h0);
    wait_idle(400);
    check_eq("single_nbits", bit_log.size(), 32'd10);
    for (int i = 0; i < 10 && i < bit_log.size(); i++)
      check_eq($sformatf("single_bit%0d", i), {31'b0, bit_log[i]}, {31'b0, exp_bits[i]});
    check_eq("single_busy_after", {31'b0, busy}, 32'd0);

    // Contention: all four held, grants rotate 0,1,2,3,0 back to back.
    do_reset();
    g0 = gnt_log.size();
    s0 = start_q.size();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    hold = 1'b1;
    req  = 4'b1111;
    wait_grants(g0 + 5, 2000);
    hold = 1'b0;
    req  = 4'b0000;
    wait_idle(800);
    for (int k = 0; k < 5 && g0 + k < gnt_log.size(); k++)
      check_eq($sformatf("contention_order%0d", k), gnt_log[g0 + k], order5[k]);
    for (int k = 0; k < 4 && s0 + k + 1 < start_q.size(); k++)
      check_eq($sformatf("contention_gap%0d", k), start_q[s0 + k + 1] - start_q[s0 + k], 32'd10);

    // Fairness wrap: last winner is 0, so 1001 goes to 3 then 0.
    g0 = gnt_log.size();
    req = 4'b1001;
    wait_grants(g0 + 2, 2000);
    wait_idle(800);
    if (gnt_log.size() >= g0 + 2) begin
      check_eq("wrap_first", gnt_log[g0], 32'd3);
      check_eq("wrap_second", gnt_log[g0 + 1], 32'd0);
    end

    // Withdrawal: req[1] pulses mid-frame and drops before the stop tick.
    g0 = gnt_log.size();
    req_data[7:0] = 8'h5A;
    req = 4'b0001;
    wait_rx_bit(2, 400);
    req_data[15:8] = 8'h77;
    req[1] = 1'b1;
    repeat (3 * tick_per) step();
    req[1] = 1'b0;
    wait_idle(800);
    check_eq("withdraw_grants", gnt_log.size() - g0, 32'd1);
    check_eq("withdraw_tx_idle", {31'b0, tx}, 32'd1);

    // Reset while bit 4 of 0x0F is on the line.
    req_data[7:0] = 8'h0F;
    req = 4'b0001;
    wait_rx_bit(5, 400);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midreset_tx", {31'b0, tx}, 32'd1);
    check_eq("midreset_busy", {31'b0, busy}, 32'd0);
    check_eq("midreset_gnt", {28'b0, gnt}, 32'd0);
    step();
    step();
    reset = 1'b0;
    zeros = 0;
    busy_cnt = 0;
    repeat (60) begin
      step();
      if (tx == 1'b0) zeros++;
      if (busy) busy_cnt++;
    end
    check_eq("midreset_quiet_tx", zeros, 32'd0);
    check_eq("midreset_quiet_busy", busy_cnt, 32'd0);
    req = 4'b0001;
    step();
    check_eq("post_reset_gnt", {28'b0, gnt}, 32'h1);
    wait_idle(400);

    // Tick spacing 5 and 17: grant latency stays one cycle.
    foreach (order5[k]) begin
      if (k < 2) begin
        tick_per = (k == 0) ? 5 : 17;
        r = $urandom_range(3);
        req_data[r*8 +: 8] = 8'($urandom);
        req[r] = 1'b1;
        step();
        check_eq($sformatf("spacing%0d_gnt", tick_per), {28'b0, gnt}, 32'd1 << r);
        wait_idle(tick_per * 14 + 40);
      end
    end

    // Randomized traffic against the reference model.
    do_reset();
    g0 = gnt_log.size();
    f0 = frames_rx;
    for (int seg = 0; seg < 6; seg++) begin
      tick_per = $urandom_range(8, 1);
      repeat (500) begin
        step();
        if ($urandom_range(19) == 0) begin
          r = $urandom_range(3);
          if (!req[r]) begin
            req_data[r*8 +: 8] = 8'($urandom);
            req[r] = 1'b1;
          end
        end
      end
    end
    wait_idle(6000);
    check_eq("random_frames_match_grants", frames_rx - f0, gnt_log.size() - g0);
    check_eq("random_exp_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
